ahb_bm_input_stage: RTL

Per-master input stage of the AHB bus matrix: the requesting end of the per-slave output arbiters. It captures a master's address phase, presents it to the matrix, and raises a transfer request. If the requested output port is not granted in that cycle, it holds the transfer and stalls the master. It then tracks the data phase and returns the owning slave's ready/response to the master.

---
 rtl/ahb_bm_input_stage_pkg.sv | 46 ++++
 rtl/ahb_bm_input_stage_if.sv | 43 ++++
 rtl/ahb_bm_addr_hold_reg.sv | 48 ++++
 rtl/ahb_bm_input_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/ahb_bm_input_stage_pkg.sv
// Shared bus-matrix definitions: AHB encodings, input-stage FSM states and the
// packed address-phase control bundle carried through the holding register.
package ahb_bm_input_stage_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      BURST_SINGLE = 3'b000,
      BURST_INCR   = 3'b001,
      BURST_WRAP4  = 3'b010,
      BURST_INCR4  = 3'b011,
      BURST_WRAP8  = 3'b100,
      BURST_INCR8  = 3'b101,
      BURST_WRAP16 = 3'b110,
      BURST_INCR16 = 3'b111
   } hburst_e;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_PEND   = 2'b01,
      ST_DPHASE = 2'b10
   } state_e;

   typedef struct packed {
      logic [1:0] trans;
      logic       write;
      logic [2:0] size;
      logic [2:0] burst;
      logic [3:0] prot;
      logic       mastlock;
   } ahb_ctrl_t;

   // Only NONSEQ and SEQ carry a real transfer; IDLE/BUSY never request a port.
   function automatic logic isValidTrans(input logic [1:0] trans);
      return trans[1];
   endfunction

endpackage

// File: rtl/ahb_bm_input_stage_if.sv
// Master-side AHB signals plus the matrix-facing request/grant/data-phase signals
// of one bus-matrix input stage.
interface ahb_bm_input_stage_if #(parameter int ADDR_WIDTH = 32);
   logic                  HSELS;
   logic [ADDR_WIDTH-1:0] HADDRS;
   logic [1:0]            HTRANSS;
   logic                  HWRITES;
   logic [2:0]            HSIZES;
   logic [2:0]            HBURSTS;
   logic [3:0]            HPROTS;
   logic                  HMASTLOCKS;
   logic                  HREADYS;
   logic                  HREADYOUTS;
   logic                  HRESPS;

   logic                  sel_s;
   logic [ADDR_WIDTH-1:0] addr_s;
   logic [1:0]            trans_s;
   logic                  write_s;
   logic [2:0]            size_s;
   logic [2:0]            burst_s;
   logic [3:0]            prot_s;
   logic                  mastlock_s;
   logic                  trans_pend;
   logic                  active;
   logic                  readyout_m;
   logic                  dphase_ready;
   logic                  dphase_resp;

   modport slave (
      input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
      output HREADYOUTS, HRESPS,
      output sel_s, addr_s, trans_s, write_s, size_s, burst_s, prot_s, mastlock_s, trans_pend,
      input  active, readyout_m, dphase_ready, dphase_resp
   );

   modport master (
      output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
      input  HREADYOUTS, HRESPS,
      input  sel_s, addr_s, trans_s, write_s, size_s, burst_s, prot_s, mastlock_s, trans_pend,
      output active, readyout_m, dphase_ready, dphase_resp
   );
endinterface

// File: rtl/ahb_bm_addr_hold_reg.sv
// Single-entry holding register for a stalled address phase, with the mux that
// selects between the held copy and the live master inputs.
module ahb_bm_addr_hold_reg
   import ahb_bm_input_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  load_i,
   input  logic                  useHeld_i,
   input  logic                  liveSel_i,
   input  logic [ADDR_WIDTH-1:0] liveAddr_i,
   input  ahb_ctrl_t             liveCtrl_i,
   output logic                  sel_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output ahb_ctrl_t             ctrl_o
);

   logic [ADDR_WIDTH-1:0] heldAddr_q, heldAddr_d;
   ahb_ctrl_t             heldCtrl_q, heldCtrl_d;

   // Capture only when a valid transfer misses its grant; otherwise keep the copy.
   always_comb begin
      heldAddr_d = heldAddr_q;
      heldCtrl_d = heldCtrl_q;
      if (load_i) begin
         heldAddr_d = liveAddr_i;
         heldCtrl_d = liveCtrl_i;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         heldAddr_q <= '0;
         heldCtrl_q <= '0;
      end else begin
         heldAddr_q <= heldAddr_d;
         heldCtrl_q <= heldCtrl_d;
      end
   end

   // A held transfer is always a selected one, so sel is forced high.
   assign sel_o  = useHeld_i ? 1'b1       : liveSel_i;
   assign addr_o = useHeld_i ? heldAddr_q : liveAddr_i;
   assign ctrl_o = useHeld_i ? heldCtrl_q : liveCtrl_i;

endmodule

// File: rtl/ahb_bm_input_stage.sv
// Per-master input stage of the AHB bus matrix: requests an output port, stalls
// the master while the port is not granted, and returns the data-phase response.
module ahb_bm_input_stage
   import ahb_bm_input_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input logic                  HCLK,
   input logic                  HRESETn,
   ahb_bm_input_stage_if.slave  bus
);

   state_e    state_q, state_d;
   logic      newTrans;
   logic      accept;
   logic      isPend;
   logic      liveSel;
   ahb_ctrl_t liveCtrl;
   ahb_ctrl_t shownCtrl;
   logic      readyOut;
   logic      respOut;

   // Masking with HRESETn keeps the request and presented select quiet during reset.
   assign newTrans = HRESETn & bus.HSELS & isValidTrans(bus.HTRANSS) & bus.HREADYS;
   assign accept   = bus.active & bus.readyout_m;
   assign isPend   = (state_q == ST_PEND);
   assign liveSel  = HRESETn & bus.HSELS;

   assign liveCtrl = '{
      trans:    (HRESETn ? bus.HTRANSS : TRANS_IDLE),
      write:    bus.HWRITES,
      size:     bus.HSIZES,
      burst:    bus.HBURSTS,
      prot:     bus.HPROTS,
      mastlock: bus.HMASTLOCKS
   };

   ahb_bm_addr_hold_reg #(.ADDR_WIDTH(ADDR_WIDTH)) uHoldReg (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .load_i     (newTrans & ~accept),
      .useHeld_i  (isPend),
      .liveSel_i  (liveSel),
      .liveAddr_i (bus.HADDRS),
      .liveCtrl_i (liveCtrl),
      .sel_o      (bus.sel_s),
      .addr_o     (bus.addr_s),
      .ctrl_o     (shownCtrl)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A completing data phase behaves like IDLE so back-to-back transfers pipeline.
   always_comb begin
      state_d  = state_q;
      readyOut = 1'b1;
      respOut  = RESP_OKAY;
      case (state_q)
         ST_PEND: begin
            readyOut = 1'b0;
            if (accept) state_d = ST_DPHASE;
         end
         ST_DPHASE: begin
            readyOut = bus.dphase_ready;
            respOut  = bus.dphase_resp;
            if (bus.dphase_ready) begin
               if (newTrans) state_d = accept ? ST_DPHASE : ST_PEND;
               else          state_d = ST_IDLE;
            end
         end
         default: begin
            if (newTrans) state_d = accept ? ST_DPHASE : ST_PEND;
            else          state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.trans_pend = newTrans | isPend;
   assign bus.HREADYOUTS = readyOut;
   assign bus.HRESPS     = respOut;
   assign bus.trans_s    = shownCtrl.trans;
   assign bus.write_s    = shownCtrl.write;
   assign bus.size_s     = shownCtrl.size;
   assign bus.burst_s    = shownCtrl.burst;
   assign bus.prot_s     = shownCtrl.prot;
   assign bus.mastlock_s = shownCtrl.mastlock;

endmodule
